// File: rtl/xg_mem_pkg.sv
// Shared definitions for the xgriscv data-memory controller.
// Holds DMType codes, FSM state encoding, the latched command payload and
// the lane/extension helpers used on both the store and the load path.
package xg_mem_pkg;

  // funct3-style access types
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  // controller FSM encoding
  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned CNT_W = 4;

  // request payload captured at acceptance (address kept separately, it is parametric)
  typedef struct packed {
    logic        we;
    logic [2:0]  dmtype;
    logic [31:0] wdata;
  } mem_cmd_t;

  // byte enables for a store of the given type at byte offset off
  function automatic logic [3:0] lane_be(input logic [2:0] t, input logic [1:0] off);
    logic [3:0] be;
    case (t[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // replicate right-aligned store data onto every lane; lane_be picks the live ones
  function automatic logic [31:0] store_align(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    case (t[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // pick the addressed lane(s) of a word and sign/zero-extend; t[2] selects zero-extend
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] t,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      DM_B, DM_BU: r = t[2] ? {24'h0, b} : {{24{b[7]}}, b};
      DM_H, DM_HU: r = t[2] ? {16'h0, h} : {{16{h[15]}}, h};
      DM_W:        r = w;
      default:     r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xg_dmem_array.sv
// DEPTH_WORDS x 32 data array with byte-enabled synchronous write and
// synchronous read. Contents are not reset.
// Ports: clk, rstn (output registers only), we/be/wdata write, re read,
// idx shared word index, rword = last read word, wword = word as left by the last write.
module xg_dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           we,
  input  logic                           re,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rword,
  output logic [31:0]                    wword
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] merged;

  // old word with the enabled lanes replaced
  always_comb begin
    merged = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // storage, never cleared
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= merged;
  end

  // read register and write-through tap for the debug display
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rword <= 32'h0;
      wword <= 32'h0;
    end else begin
      if (re) rword <= mem[idx];
      if (we) wword <= merged;
    end
  end

endmodule

// File: rtl/xg_dmem_ctrl.sv
// Handshaked multi-cycle data-memory controller for the xgriscv MEM stage.
// Accepts one access in IDLE, waits WAIT_CYCLES, commits on the edge into
// RESP and pulses ack (with err for trapped accesses).
// Ports: clk, rstn (sync, active-low); req/we/dmtype/addr/wdata request;
// rdata/ack/err response; stall to the hazard unit; dbg_addr/dbg_data last store.
module xg_dmem_ctrl
  import xg_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        dmtype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              err,
  output logic              stall,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned LIM_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = LIM_W'(DEPTH_WORDS * 4);

  logic [STATE_W-1:0] state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               latch, commit;

  mem_cmd_t          cmd_q, acc_cmd;
  logic [ADDR_W-1:0] addr_q, acc_addr;
  logic              trap;
  logic              mem_we, mem_re;
  logic [31:0]       rword;

  logic              zero_q;
  logic [2:0]        ld_type_q;
  logic [1:0]        ld_off_q;

  // in IDLE the access is still on the inputs; afterwards use the latched copy
  always_comb begin
    if (state == S_IDLE) begin
      acc_cmd  = {we, dmtype, wdata};
      acc_addr = addr;
    end else begin
      acc_cmd  = cmd_q;
      acc_addr = addr_q;
    end
  end

  // trap decode
  always_comb begin
    trap = 1'b0;
    case (acc_cmd.dmtype)
      DM_B:    trap = 1'b0;
      DM_H:    trap = acc_addr[0];
      DM_W:    trap = |acc_addr[1:0];
      DM_BU:   trap = acc_cmd.we;
      DM_HU:   trap = acc_cmd.we | acc_addr[0];
      default: trap = 1'b1;
    endcase
    if ({1'b0, acc_addr} >= ADDR_LIMIT) trap = 1'b1;
  end

  // next state; commit marks the edge into RESP
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_n = S_RESP;
            commit  = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // array strobes are gated by reset so an access aborted in WAIT never lands
  assign mem_we = commit & rstn & acc_cmd.we & ~trap;
  assign mem_re = commit & rstn & ~acc_cmd.we & ~trap;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      zero_q    <= 1'b1;
      ld_type_q <= DM_W;
      ld_off_q  <= 2'b00;
      dbg_addr  <= '0;
    end else begin
      ack <= commit;
      err <= commit & trap;
      if (latch) begin
        cmd_q  <= acc_cmd;
        addr_q <= acc_addr;
      end
      // loads and trapped accesses redefine rdata; good stores leave it alone
      if (commit && (trap || !acc_cmd.we)) begin
        zero_q    <= trap;
        ld_type_q <= acc_cmd.dmtype;
        ld_off_q  <= acc_addr[1:0];
      end
      if (mem_we) dbg_addr <= acc_addr;
    end
  end

  xg_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .we    (mem_we),
    .re    (mem_re),
    .be    (lane_be(acc_cmd.dmtype, acc_addr[1:0])),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (store_align(acc_cmd.dmtype, acc_cmd.wdata)),
    .rword (rword),
    .wword (dbg_data)
  );

  // read register only changes on load commits, so rdata holds between acks
  assign rdata = zero_q ? 32'h0 : load_ext(rword, ld_type_q, ld_off_q);
  assign stall = req & ~ack;

endmodule

// File: tb/tb_xg_dmem_ctrl.sv
// Bench for xg_dmem_ctrl: one instance with WAIT_CYCLES=2, one with 0.
// Expected responses are queued at drive time and matched against acks.
module tb_xg_dmem_ctrl;
  import xg_mem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
    logic        chk;
  } stim_t;

  logic        clk, rstn;
  logic        req, we, ack, err, stall;
  logic [2:0]  dmtype;
  logic [31:0] addr, wdata, rdata, dbg_addr, dbg_data;
  logic        req0, we0, ack0, err0, stall0;
  logic [2:0]  dmtype0;
  logic [31:0] addr0, wdata0, rdata0, dbg_addr0, dbg_data0;

  rsp_t exp_q[$], obs_q[$], exp0_q[$], obs0_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  xg_dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .dmtype(dmtype), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .stall(stall),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  xg_dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req(req0), .we(we0), .dmtype(dmtype0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .stall(stall0),
    .dbg_addr(dbg_addr0), .dbg_data(dbg_data0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // response monitor
  always @(negedge clk) begin
    if (ack === 1'b1)  obs_q.push_back({rdata, err, 1'b1});
    if (ack0 === 1'b1) obs0_q.push_back({rdata0, err0, 1'b1});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drive one access on the WAIT_CYCLES=2 instance and wait (bounded) for ack
  task automatic run_acc(input logic w, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                         input logic chk, input logic scramble,
                         output int lat, output logic [3:0] sh);
    exp_q.push_back({exp_rd, exp_err, chk});
    @(posedge clk); #1;
    req = 1'b1; we = w; dmtype = t; addr = a; wdata = d;
    lat = -1;
    sh  = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 4) sh[k] = stall;
      if (scramble && k == 1) begin
        req = 1'b0; we = ~w; dmtype = 3'b111; addr = ~a; wdata = ~d;
      end
      if (ack === 1'b1) begin
        lat = k;
        break;
      end
    end
    req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || dbg_addr !== 32'h0 || dbg_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack=%b err=%b rdata=%08h dbg=%08h/%08h, required all 0",
               ack, err, rdata, dbg_addr, dbg_data);
    end
    n_cmp++;
    if (ack0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'h0 || dbg_addr0 !== 32'h0 || dbg_data0 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs0: got ack=%b err=%b rdata=%08h, required all 0", ack0, err0, rdata0);
    end
    req = 1'b1; #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL reset_stall_hi: got %b required 1", stall);
    end
    req = 1'b0; #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall_lo: got %b required 0", stall);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_word();
    int lat;
    logic [3:0] sh;
    rsp_t e, o;
    run_acc(1'b1, DM_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, lat, sh);
    n_cmp++;
    if (lat !== 3 || sh !== 4'b0111) begin
      n_bad++; $display("FAIL sw_timing: got ack cycle %0d stall %b, required 3 and 0111", lat, sh);
    end
    n_cmp++;
    if (dbg_addr !== 32'h10 || dbg_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sw_dbg: got %08h/%08h required 00000010/deadbeef", dbg_addr, dbg_data);
    end
    run_acc(1'b0, DM_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, lat, sh);
    n_cmp++;
    if (lat !== 3 || sh !== 4'b0111) begin
      n_bad++; $display("FAIL lw_timing: got ack cycle %0d stall %b, required 3 and 0111", lat, sh);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL word[%0d]: no ack, required err=%b rdata=%08h", i, e.err, e.rdata);
      end else begin
        o = obs_q.pop_front();
        if (o.err !== e.err || (e.chk && o.rdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL word[%0d]: got err=%b rdata=%08h, required err=%b rdata=%08h",
                   i, o.err, o.rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_byte_half();
    int lat;
    logic [3:0] sh;
    rsp_t e, o;
    stim_t tbl [7];
    tbl[0] = '{1'b1, DM_B,  32'h13, 32'h000000AA, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, DM_W,  32'h10, 32'h0,        32'hAAADBEEF, 1'b0, 1'b1};
    tbl[2] = '{1'b0, DM_B,  32'h13, 32'h0,        32'hFFFFFFAA, 1'b0, 1'b1};
    tbl[3] = '{1'b0, DM_BU, 32'h13, 32'h0,        32'h000000AA, 1'b0, 1'b1};
    tbl[4] = '{1'b0, DM_HU, 32'h12, 32'h0,        32'h0000AAAD, 1'b0, 1'b1};
    tbl[5] = '{1'b0, DM_B,  32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b1};
    tbl[6] = '{1'b0, DM_H,  32'h12, 32'h0,        32'hFFFFAAAD, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      run_acc(tbl[i].we, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].er, tbl[i].chk, 1'b0, lat, sh);
      if (i == 0) begin
        n_cmp++;
        if (dbg_addr !== 32'h13 || dbg_data !== 32'hAAADBEEF) begin
          n_bad++; $display("FAIL sb_dbg: got %08h/%08h required 00000013/aaadbeef", dbg_addr, dbg_data);
        end
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL bh[%0d]: no ack, required err=%b rdata=%08h", i, e.err, e.rdata);
      end else begin
        o = obs_q.pop_front();
        if (lat !== 3 || o.err !== e.err || (e.chk && o.rdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL bh[%0d]: got cyc=%0d err=%b rdata=%08h, required cyc=3 err=%b rdata=%08h",
                   i, lat, o.err, o.rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_traps();
    int lat;
    logic [3:0] sh;
    rsp_t e, o;
    stim_t tbl [13];
    tbl[0]  = '{1'b0, DM_H,   32'h11,   32'h0,        32'h0,        1'b1, 1'b1};
    tbl[1]  = '{1'b1, DM_W,   32'h12,   32'h12345678, 32'h0,        1'b1, 1'b1};
    tbl[2]  = '{1'b0, DM_W,   32'h10,   32'h0,        32'hAAADBEEF, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, DM_W,   32'h1000, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[4]  = '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1, 1'b1};
    tbl[5]  = '{1'b1, DM_BU,  32'h10,   32'h55555555, 32'h0,        1'b1, 1'b1};
    tbl[6]  = '{1'b0, DM_W,   32'h10,   32'h0,        32'hAAADBEEF, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 3'b110, 32'h10,   32'h0,        32'h0,        1'b1, 1'b1};
    tbl[8]  = '{1'b1, DM_W,   32'hFFC,  32'h0BADCAFE, 32'h0,        1'b0, 1'b0};
    tbl[9]  = '{1'b0, DM_W,   32'hFFC,  32'h0,        32'h0BADCAFE, 1'b0, 1'b1};
    tbl[10] = '{1'b1, DM_H,   32'h16,   32'h1234BEEF, 32'h0,        1'b0, 1'b0};
    tbl[11] = '{1'b0, DM_H,   32'h16,   32'h0,        32'hFFFFBEEF, 1'b0, 1'b1};
    tbl[12] = '{1'b0, DM_HU,  32'h16,   32'h0,        32'h0000BEEF, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      run_acc(tbl[i].we, tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].er, tbl[i].chk, 1'b0, lat, sh);
      if (i == 1) begin
        n_cmp++;
        if (dbg_addr !== 32'h13 || dbg_data !== 32'hAAADBEEF) begin
          n_bad++; $display("FAIL trap_dbg: got %08h/%08h required 00000013/aaadbeef", dbg_addr, dbg_data);
        end
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL trap[%0d]: no ack, required err=%b rdata=%08h", i, e.err, e.rdata);
      end else begin
        o = obs_q.pop_front();
        if (lat !== 3 || o.err !== e.err || (e.chk && o.rdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL trap[%0d]: got cyc=%0d err=%b rdata=%08h, required cyc=3 err=%b rdata=%08h",
                   i, lat, o.err, o.rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_latch();
    int lat;
    logic [3:0] sh;
    rsp_t e, o;
    run_acc(1'b1, DM_W, 32'h30, 32'hA5A5F00F, 32'h0, 1'b0, 1'b0, 1'b1, lat, sh);
    n_cmp++;
    if (dbg_addr !== 32'h30 || dbg_data !== 32'hA5A5F00F) begin
      n_bad++; $display("FAIL latch_dbg: got %08h/%08h required 00000030/a5a5f00f", dbg_addr, dbg_data);
    end
    run_acc(1'b0, DM_W, 32'h30, 32'h0, 32'hA5A5F00F, 1'b0, 1'b1, 1'b1, lat, sh);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL latch[%0d]: no ack, required err=%b rdata=%08h", i, e.err, e.rdata);
      end else begin
        o = obs_q.pop_front();
        if (o.err !== e.err || (e.chk && o.rdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL latch[%0d]: got err=%b rdata=%08h, required err=%b rdata=%08h",
                   i, o.err, o.rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int lat;
    logic [3:0] sh;
    rsp_t e, o;
    run_acc(1'b1, DM_W, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b0, lat, sh);
    // abort a second store to the same word in its last WAIT cycle
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; dmtype = DM_W; addr = 32'h20; wdata = 32'h55AA55AA;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    req  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || dbg_addr !== 32'h0 ||
          dbg_data !== 32'h0 || stall !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_wait[%0d]: got ack=%b err=%b rdata=%08h dbg=%08h/%08h stall=%b, required all 0",
                 k, ack, err, rdata, dbg_addr, dbg_data, stall);
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    // only the completed first store may have acked
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_bad++; $display("FAIL rst_wait_acks: got %0d acks required 1", obs_q.size());
    end
    run_acc(1'b0, DM_W, 32'h20, 32'h0, 32'h11223344, 1'b0, 1'b1, 1'b0, lat, sh);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL rst_wait_rsp[%0d]: no ack, required rdata=%08h", i, e.rdata);
      end else begin
        o = obs_q.pop_front();
        if (o.err !== e.err || (e.chk && o.rdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL rst_wait_rsp[%0d]: got err=%b rdata=%08h, required err=%b rdata=%08h",
                   i, o.err, o.rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic got;
    logic odd;
    rsp_t e, o;
    // preload a word in the zero-wait instance
    exp0_q.push_back({32'h0, 1'b0, 1'b0});
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; dmtype0 = DM_W; addr0 = 32'h4; wdata0 = 32'hCAFEF00D;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    req0 = 1'b0;
    #1;
    n_cmp++;
    if (got !== 1'b1 || dbg_addr0 !== 32'h4 || dbg_data0 !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL b2b_preload: got ack=%b dbg=%08h/%08h, required 1 00000004/cafef00d",
               got, dbg_addr0, dbg_data0);
    end
    // four loads with req held high
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; dmtype0 = DM_W; addr0 = 32'h4;
    for (int i = 0; i < 4; i++) exp0_q.push_back({32'hCAFEF00D, 1'b0, 1'b1});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      odd = ((k % 2) == 1);
      n_cmp++;
      if (ack0 !== odd || stall0 !== ~odd) begin
        n_bad++;
        $display("FAIL b2b_cycle[%0d]: got ack=%b stall=%b, required ack=%b stall=%b",
                 k, ack0, stall0, odd, ~odd);
      end
      if (k == 7) req0 = 1'b0;
    end
    #1;
    for (int i = 0; i < 5; i++) begin
      e = exp0_q.pop_front();
      n_cmp++;
      if (obs0_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_rsp[%0d]: no ack, required rdata=%08h", i, e.rdata);
      end else begin
        o = obs0_q.pop_front();
        if (o.err !== e.err || (e.chk && o.rdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL b2b_rsp[%0d]: got err=%b rdata=%08h, required err=%b rdata=%08h",
                   i, o.err, o.rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    req = 1'b0; we = 1'b0; dmtype = DM_W; addr = 32'h0; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; dmtype0 = DM_W; addr0 = 32'h0; wdata0 = 32'h0;
    test_reset();
    test_word();
    test_byte_half();
    test_traps();
    test_latch();
    test_reset_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
